sub64_seq: RTL
==============

// Module: sub64_seq
// PURPOSE
//  Multi-cycle unsigned/two's-complement subtractor: D = A - B - BIN over WIDTH bits.
//  Processes one CHUNK-bit slice per clock, LSB slice first, with a rippled borrow
//  between slices. Inverse companion to the carry-lookahead adder datapath.
//  Sits behind a valid/ready request port and a valid/ready result port.
// PARAMETERS
//  WIDTH  64  operand/result width; must be an integer multiple of CHUNK
//  CHUNK  16  bits subtracted per cycle; N = WIDTH/CHUNK slice cycles (default N=4)
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      request valid
//  in_ready   out  1      block idle, request accepted when in_valid & in_ready
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result valid, held until taken
//  out_ready  in   1      result consumer ready
//  d          out  WIDTH  difference a - b - bin (mod 2^WIDTH)
//  bout       out  1      borrow out: 1 iff a < b + bin (unsigned)
//  ovf        out  1      signed overflow: a[MSB]!=b[MSB] && d[MSB]!=a[MSB]
//  zero       out  1      d == 0
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, slice counter=0, out_valid=0, d=0,
//   bout=0, ovf=0, zero=0; in_ready reads 1 from first cycle after reset edge.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid: latch a,b,bin; borrow register=bin; cnt=0; -> RUN.
//   RUN : in_ready=0. Each edge slice k=cnt: {c,dk} = a[k] + ~b[k] + ~borrow;
//         d[k*CHUNK +: CHUNK] <= dk; borrow <= ~c; cnt++. After slice N-1 -> DONE.
//   DONE: out_valid=1, in_ready=0; d,bout,ovf,zero stable. On out_ready -> IDLE,
//         out_valid=0 next cycle. d/flags keep last value in IDLE.
//  Latency: acceptance edge E0; slices on E1..EN; out_valid high after EN
//   (N cycles after acceptance). Min throughput: one op per N+2 cycles.
//  bout = final borrow; ovf, zero computed from full latched d at transition to DONE.
//  Partial d bits not observable as valid before out_valid.
//  in_valid while not IDLE: ignored, operands not captured, no effect on state.
//  out_ready while not DONE: ignored.
//  out_ready held low: DONE indefinitely, all outputs constant.
//  Reset mid-RUN or mid-DONE: operation abandoned, no result emitted, reset values.
//  Inputs a,b,bin sampled only at acceptance; changes later have no effect.
//  Slice arithmetic exact mod 2^CHUNK; borrow ripples across all N slices.
// TESTING
//  1 a=5,b=3,bin=0 -> d=2,bout=0,ovf=0,zero=0; out_valid exactly 4 cycles after accept.
//  2 a=0,b=1,bin=0 -> d=64'hFFFF_FFFF_FFFF_FFFF,bout=1,ovf=0 (borrow ripples 4 slices).
//  3 a=64'h8000_0000_0000_0000,b=1 -> d=64'h7FFF_FFFF_FFFF_FFFF,ovf=1,bout=0.
//  4 a=b=64'h1234_5678_9ABC_DEF0: bin=0 -> d=0,zero=1,bout=0;
//    bin=1 -> d=all ones,bout=1,zero=0.
//  5 out_ready low 10 cycles in DONE, in_valid pulsed -> outputs constant,
//    in_ready=0, no capture; out_ready=1 -> IDLE; next request computes correctly.
//  6 rst_n=0 on second RUN cycle -> out_valid never rises, outputs 0, in_ready=1;
//    following request a=10,b=4 -> d=6.
//  Plus randomized a,b,bin against a-b-bin reference model, random out_ready stalls.

Source files
------------

// File: rtl/sub64_seq.sv
// Sequential WIDTH-bit subtractor d = a - b - bin. One CHUNK-bit slice per clock,
// LSB first, borrow rippled between slices, behind valid/ready request/result ports.
module sub64_slice #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);
  logic [CHUNK:0] sum;

  // a - b - bin == a + ~b + ~bin; the carry out is the inverted borrow out
  assign sum  = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, ~bin};
  assign d    = sum[CHUNK-1:0];
  assign bout = ~sum[CHUNK];
endmodule

module sub64_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [N-1:0][CHUNK-1:0] a;
    logic [N-1:0][CHUNK-1:0] b;
  } opnd_t;

  state_t                  state;
  opnd_t                   op;
  logic                    borrow;
  logic [CW-1:0]           cnt;
  logic [N-1:0][CHUNK-1:0] d_q;
  logic [N-1:0][CHUNK-1:0] d_nxt;
  logic [CHUNK-1:0]        dk;
  logic                    bout_k;
  logic                    last;

  sub64_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (op.a[cnt]),
    .b    (op.b[cnt]),
    .bin  (borrow),
    .d    (dk),
    .bout (bout_k)
  );

  // Result with the current slice merged in, so flags see the complete value
  always_comb begin
    d_nxt      = d_q;
    d_nxt[cnt] = dk;
  end

  assign last = (cnt == CW'(N - 1));
  assign d    = d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      d_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op       <= '{a: a, b: b};
          borrow   <= bin;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          d_q    <= d_nxt;
          borrow <= bout_k;
          cnt    <= cnt + 1'b1;
          if (last) begin
            bout      <= bout_k;
            zero      <= (d_nxt == '0);
            ovf       <= (op.a[N-1][CHUNK-1] != op.b[N-1][CHUNK-1]) &&
                         (d_nxt[N-1][CHUNK-1] != op.a[N-1][CHUNK-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
